whack_mole_engine: RTL and testbench
====================================

WHACK_MOLE_ENGINE -- requirements
Module: whack_mole_engine

Interface
REQ-001 Parameter N_MOLES, default 9: number of mole LEDs and buttons, legal 2..16.
REQ-002 Parameter MOLE_TICKS, default 100000000: cin cycles a mole stays lit (2 s at 50 MHz), legal >= 2.
REQ-003 Parameter GAP_TICKS, default 25000000: dark cycles between moles, legal >= 1.
REQ-004 Parameter ROUND_LEN, default 20: moles per round, legal 1..255.
REQ-005 Parameter LFSR_SEED, default 8'h01: LFSR reset value, legal non-zero.
REQ-006 cin  in  1  system clock; the only clock.
REQ-007 KEY0  in  1  reset; asynchronous, active-low.
REQ-008 start  in  1  level; starts a round from IDLE or DONE.
REQ-009 SW  in  N_MOLES  breadboard push buttons, asynchronous, active-high.
REQ-010 LEDR  out  N_MOLES  mole LEDs; one-hot while a mole is up, else zero.
REQ-011 HEX0  out  8  ones digit of score; active-low segments, bit7 = dp (held 1).
REQ-012 HEX1  out  8  tens digit of score; same encoding.
REQ-013 score  out  7  binary score, 0..99.
REQ-014 busy  out  1  high in SPAWN, UP and GAP.
REQ-015 done  out  1  high in DONE.

Function
REQ-016 Each SW bit SHALL pass a 2-flop synchroniser, then a rising-edge detector producing a 1-cycle pulse hit_pulse[i].
REQ-017 An 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, SHALL advance every cycle outside reset; it never holds zero.
REQ-018 FSM states SHALL be IDLE, SPAWN, UP, GAP, DONE.
REQ-019 IDLE: LEDR=0; start=1 -> clear score and mole count -> SPAWN.
REQ-020 SPAWN (1 cycle): idx = lfsr mod N_MOLES; if idx equals previous idx, idx = (idx+1) mod N_MOLES; load timer with MOLE_TICKS-1; -> UP.
REQ-021 UP: LEDR = 1<<idx; timer decrements each cycle.
REQ-022 UP with hit_pulse[idx]=1: score increments (saturates at 99), -> GAP; hit_pulse on other bits in the same or other cycles is ignored.
REQ-023 UP with timer=0 and no hit: -> GAP, score unchanged; mole lit exactly MOLE_TICKS cycles.
REQ-024 Hit and timeout in the same cycle: hit wins.
REQ-025 GAP: LEDR=0 for GAP_TICKS cycles; mole count increments on entry; at expiry, count=ROUND_LEN -> DONE, else -> SPAWN.
REQ-026 DONE: LEDR=0, score held; start=1 -> clear score and count -> SPAWN.
REQ-027 start in SPAWN/UP/GAP SHALL be ignored.
REQ-028 Latency: SW rising at a cin edge k (first sampled high) -> score and LEDR update visible after edge k+3.
REQ-029 HEX1/HEX0 SHALL show score/10 and score%10, combinationally from registered score; tens digit shows 0 (not blank).

Reset
REQ-030 KEY0=0 SHALL immediately force: state IDLE, LEDR=0, score=0, mole count=0, timer=0, LFSR=LFSR_SEED, sync/edge flops=0, previous idx=N_MOLES-1.
REQ-031 HEX0=HEX1=8'hC0 (digit 0, dp off), busy=0, done=0 during and after reset.
REQ-032 Reset mid-round SHALL abandon the round; no state survives; KEY0 release is synchronised internally before FSM leaves IDLE.

Structure
REQ-033 Package whack_pkg SHALL hold the FSM state enum, the 10-entry seven-segment table constant and the LFSR tap mask.
REQ-034 Sub-module seg7_decode (4-bit digit -> 8-bit active-low segments) SHALL be instantiated twice.
REQ-035 Timer width = $clog2(MAX(MOLE_TICKS, GAP_TICKS)); no 36-bit free-running counters.

Verification (N_MOLES=9, MOLE_TICKS=10, GAP_TICKS=4, ROUND_LEN=3)
REQ-036 Reset release, no start -> LEDR=0, HEX0=HEX1=8'hC0, busy=0 indefinitely.
REQ-037 start pulse, press SW[idx] 2 cycles after LEDR lights -> score=1 at edge+3, HEX0=8'hF9, LEDR=0 for 4 cycles.
REQ-038 start, no presses -> each mole lit exactly 10 cycles, 3 moles, consecutive idx differ, done=1, score=0.
REQ-039 Press wrong button then hold right button through timeout boundary -> wrong ignored, hit counted once, held button does not re-score.
REQ-040 Force score to 99 via repeated rounds, hit again -> score stays 99, HEX1=HEX0=8'h90.
REQ-041 Assert KEY0=0 mid-UP -> LEDR=0 and score=0 same cycle, state IDLE after release.

Source files
------------

// File: rtl/whack_pkg.sv
// whack_pkg: shared FSM state type, seven-segment table and LFSR taps
// for the whack-a-mole engine.
package whack_pkg;

    typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, DONE} state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [6:0] SCORE_MAX = 7'd99;

    // active-low segments {dp,g,f,e,d,c,b,a}, dp held off
    localparam logic [7:0] SEG7_TABLE [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

endpackage

// File: rtl/whack_mole_engine_if.sv
// whack_mole_engine_if: player-facing controls and displays of the engine.
interface whack_mole_engine_if #(parameter int N_MOLES = 9);

    logic               start;
    logic [N_MOLES-1:0] SW;
    logic [N_MOLES-1:0] LEDR;
    logic [7:0]         HEX0;
    logic [7:0]         HEX1;
    logic [6:0]         score;
    logic               busy;
    logic               done;

    modport master (output start, SW, input LEDR, HEX0, HEX1, score, busy, done);
    modport slave  (input start, SW, output LEDR, HEX0, HEX1, score, busy, done);

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit decimal digit to active-low seven-segment pattern;
// non-decimal codes blank the display.
module seg7_decode
    import whack_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    assign seg = (digit < 4'd10) ? SEG7_TABLE[digit] : 8'hFF;

endmodule

// File: rtl/whack_mole_engine.sv
// whack_mole_engine: one mole at a time picked by an LFSR, hits on the lit
// button score (saturating at 99), decimal score shown on two digits.
module whack_mole_engine
    import whack_pkg::*;
#(
    parameter int         N_MOLES    = 9,
    parameter int         MOLE_TICKS = 100000000,
    parameter int         GAP_TICKS  = 25000000,
    parameter int         ROUND_LEN  = 20,
    parameter logic [7:0] LFSR_SEED  = 8'h01
)(
    input logic              cin,
    input logic              KEY0,
    whack_mole_engine_if.slave bus
);

    localparam int TW = $clog2(MOLE_TICKS > GAP_TICKS ? MOLE_TICKS : GAP_TICKS);
    localparam int IW = $clog2(N_MOLES);

    state_t             state, state_nx;
    logic [1:0]         rst_q;
    logic [N_MOLES-1:0] s1, s2, s3, hit_pulse;
    logic [7:0]         lfsr;
    logic [TW-1:0]      timer, timer_nx;
    logic [IW-1:0]      idx, idx_nx, cand;
    logic [6:0]         score, score_nx;
    logic [7:0]         count, count_nx;
    logic [3:0]         ones, tens;
    logic               hit;

    always_ff @(posedge cin or negedge KEY0) begin
        if (!KEY0) begin
            rst_q     <= '0;
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            hit_pulse <= '0;
            lfsr      <= LFSR_SEED;
            state     <= IDLE;
            timer     <= '0;
            idx       <= IW'(N_MOLES - 1);
            score     <= '0;
            count     <= '0;
        end else begin
            rst_q     <= {rst_q[0], 1'b1};
            s1        <= bus.SW;
            s2        <= s1;
            s3        <= s2;
            hit_pulse <= s2 & ~s3;
            lfsr      <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
            state     <= state_nx;
            timer     <= timer_nx;
            idx       <= idx_nx;
            score     <= score_nx;
            count     <= count_nx;
        end
    end

    assign cand = IW'(lfsr % 8'(N_MOLES));
    assign hit  = hit_pulse[idx];

    // rst_q[1] keeps the round from starting until KEY0 release has been synchronised
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        idx_nx   = idx;
        score_nx = score;
        count_nx = count;
        case (state)
            IDLE, DONE: if (bus.start && rst_q[1]) begin
                score_nx = '0;
                count_nx = '0;
                state_nx = SPAWN;
            end
            SPAWN: begin
                idx_nx   = (cand != idx) ? cand :
                           (cand == IW'(N_MOLES - 1)) ? '0 : cand + IW'(1);
                timer_nx = TW'(MOLE_TICKS - 1);
                state_nx = UP;
            end
            UP: if (hit || timer == '0) begin
                score_nx = (hit && score != SCORE_MAX) ? score + 7'd1 : score;
                count_nx = count + 8'd1;
                timer_nx = TW'(GAP_TICKS - 1);
                state_nx = GAP;
            end else begin
                timer_nx = timer - TW'(1);
            end
            GAP: if (timer == '0) begin
                state_nx = (count == 8'(ROUND_LEN)) ? DONE : SPAWN;
            end else begin
                timer_nx = timer - TW'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.LEDR  = (state == UP) ? N_MOLES'(1) << idx : '0;
    assign bus.score = score;
    assign bus.busy  = state inside {SPAWN, UP, GAP};
    assign bus.done  = state == DONE;

    assign ones = 4'(score % 7'd10);
    assign tens = 4'(score / 7'd10);

    seg7_decode u_ones (.digit(ones), .seg(bus.HEX0));
    seg7_decode u_tens (.digit(tens), .seg(bus.HEX1));

endmodule

// File: tb/tb_whack_mole_engine.sv
// tb_whack_mole_engine: directed checks of round flow, hit latency, timeout,
// reset and score saturation on two engine instances.
module tb_whack_mole_engine;

    logic cin  = 1'b0;
    logic KEY0 = 1'b0;

    int total = 0;
    int bad   = 0;
    int e_prev, e_idx, e_score;
    logic [7:0] m_lfsr;
    logic [7:0] seg_t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    whack_mole_engine_if #(.N_MOLES(9)) b1 ();
    whack_mole_engine_if #(.N_MOLES(4)) b2 ();

    whack_mole_engine #(.N_MOLES(9), .MOLE_TICKS(10), .GAP_TICKS(4),
                        .ROUND_LEN(3), .LFSR_SEED(8'h01))
        dut (.cin(cin), .KEY0(KEY0), .bus(b1));

    whack_mole_engine #(.N_MOLES(4), .MOLE_TICKS(8), .GAP_TICKS(1),
                        .ROUND_LEN(101), .LFSR_SEED(8'h5A))
        dut2 (.cin(cin), .KEY0(KEY0), .bus(b2));

    always #5 cin = ~cin;

    // reference LFSR for predicting which mole lights
    always @(posedge cin or negedge KEY0)
        if (!KEY0) m_lfsr <= 8'h01;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    task automatic tick();
        @(negedge cin);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic spawn_chk();
        int c;
        chk("spawn_busy", 32'(b1.busy), 1);
        chk("spawn_dark", 32'(b1.LEDR), 0);
        c = int'(m_lfsr) % 9;
        e_idx = (c == e_prev) ? (c + 1) % 9 : c;
        e_prev = e_idx;
    endtask

    // p: lit-cycle index at which the right button is pressed (<0 none),
    // w: also press the neighbouring wrong button, s: wiggle start mid-mole
    task automatic mole(input int p, input bit w, input bit s);
        int n_lit;
        bit hit;
        logic [8:0] led;
        spawn_chk();
        led   = 9'(1) << e_idx;
        hit   = p >= 0 && p <= 6;
        n_lit = hit ? p + 4 : 10;
        for (int c = 0; c < n_lit; c++) begin
            tick();
            chk("lit", 32'(b1.LEDR), 32'(led));
            if (c == n_lit - 1) chk("pre_score", 32'(b1.score), e_score);
            if (c == 0 && w) b1.SW = {led[7:0], led[8]};
            if (c == p) b1.SW = b1.SW | led;
            b1.start = s && c < 3;
        end
        if (hit) e_score = (e_score < 99) ? e_score + 1 : 99;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("gap_dark", 32'(b1.LEDR), 0);
            chk("gap_score", 32'(b1.score), e_score);
        end
        chk("hex0", 32'(b1.HEX0), 32'(seg_t[e_score % 10]));
        chk("hex1", 32'(b1.HEX1), 32'(seg_t[e_score / 10]));
        b1.SW = '0;
        tick();
    endtask

    task automatic begin_round();
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        e_score = 0;
    endtask

    task automatic end_round();
        chk("done", 32'(b1.done), 1);
        chk("done_busy", 32'(b1.busy), 0);
        chk("done_dark", 32'(b1.LEDR), 0);
        chk("done_score", 32'(b1.score), e_score);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        b1.start = 1'b0;
        b1.SW    = '0;
        b2.start = 1'b0;
        b2.SW    = '0;
        e_prev   = 8;
        e_score  = 0;
        repeat (3) tick();
        chk("rst_led", 32'(b1.LEDR), 0);
        chk("rst_hex0", 32'(b1.HEX0), 32'h00C0);
        chk("rst_hex1", 32'(b1.HEX1), 32'h00C0);
        chk("rst_busy", 32'(b1.busy), 0);
        chk("rst_done", 32'(b1.done), 0);
        chk("rst_score", 32'(b1.score), 0);
        KEY0 = 1'b1;
        repeat (20) tick();
        chk("idle_led", 32'(b1.LEDR), 0);
        chk("idle_hex0", 32'(b1.HEX0), 32'h00C0);
        chk("idle_hex1", 32'(b1.HEX1), 32'h00C0);
        chk("idle_busy", 32'(b1.busy), 0);

        // round 1: early hit, timeout with start ignored, wrong+held hit on last lit cycle
        begin_round();
        mole(2, 1'b0, 1'b0);
        mole(-1, 1'b0, 1'b1);
        mole(6, 1'b1, 1'b0);
        end_round();

        // round 2: no presses, every mole times out
        begin_round();
        mole(-1, 1'b0, 1'b0);
        mole(-1, 1'b0, 1'b0);
        mole(-1, 1'b0, 1'b0);
        end_round();

        // round 3: late press lands in the gap, then a hit, then reset mid-UP
        begin_round();
        mole(7, 1'b0, 1'b0);
        mole(0, 1'b0, 1'b0);
        spawn_chk();
        tick();
        tick();
        chk("pre_rst_led", 32'(b1.LEDR), 32'(9'(1) << e_idx));
        chk("pre_rst_score", 32'(b1.score), 1);
        KEY0 = 1'b0;
        #1;
        chk("mid_rst_led", 32'(b1.LEDR), 0);
        chk("mid_rst_score", 32'(b1.score), 0);
        chk("mid_rst_busy", 32'(b1.busy), 0);
        chk("mid_rst_hex0", 32'(b1.HEX0), 32'h00C0);
        e_prev  = 8;
        e_score = 0;
        tick();
        KEY0     = 1'b1;
        b1.start = 1'b1;
        tick();
        chk("sync_idle1", 32'(b1.busy), 0);
        tick();
        chk("sync_idle2", 32'(b1.busy), 0);
        b1.start = 1'b0;
        tick();
        chk("sync_idle3", 32'(b1.busy), 0);

        // round 4: fresh round after reset
        begin_round();
        mole(1, 1'b0, 1'b0);
        mole(-1, 1'b0, 1'b0);
        mole(3, 1'b0, 1'b0);
        end_round();

        // second engine: 101 hits in one round saturate the score at 99
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
        for (int h = 0; h < 101; h++) begin
            w = 0;
            while (b2.LEDR == '0 && w < 10) begin
                tick();
                w++;
            end
            if (b2.LEDR == '0) begin
                chk("sat_mole_lit", 32'(b2.LEDR != '0), 1);
                break;
            end
            b2.SW = b2.LEDR;
            repeat (4) tick();
            b2.SW = '0;
            if (h == 0)  chk("sat_first", 32'(b2.score), 1);
            if (h == 98) chk("sat_reach99", 32'(b2.score), 99);
        end
        chk("sat_score", 32'(b2.score), 99);
        chk("sat_hex0", 32'(b2.HEX0), 32'h0090);
        chk("sat_hex1", 32'(b2.HEX1), 32'h0090);
        w = 0;
        while (!b2.done && w < 10) begin
            tick();
            w++;
        end
        chk("sat_done", 32'(b2.done), 1);
        chk("sat_done_score", 32'(b2.score), 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
